// File: rtl/vga_text_buffer_if.sv
// Command port between the CPU/MMIO side and the text-buffer terminal engine.
// A command transfers on any clock where cmd_valid and cmd_ready are both high.
interface vga_text_buffer_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_ch;
    logic [DATA_W-1:0] cmd_color;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_ch, cmd_color,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_ch, cmd_color,
        output cmd_ready
    );
endinterface

// File: rtl/vga_text_buffer.sv
// Character/colour frame store with a terminal engine (putc, write, clear, cursor, auto-scroll).
// Port A feeds the VGA scan-out; port B belongs to the engine and is never allowed to stall port A.
module vga_text_buffer #(
    parameter int COLS     = 96,
    parameter int ROWS     = 32,
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int BLANK_CH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] ch,
    output logic [DATA_W-1:0] color,
    vga_text_buffer_if.slave  cmd,
    output logic [ADDR_W-1:0] cursor_addr,
    output logic              busy
);
    localparam int CELLS = COLS * ROWS;
    localparam logic [ADDR_W-1:0] CELLS_A   = ADDR_W'(CELLS);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(COLS * (ROWS - 1));
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
    localparam logic [DATA_W-1:0] BLANK_D   = DATA_W'(BLANK_CH);
    localparam logic [DATA_W-1:0] NL_CH     = DATA_W'(10);
    localparam logic [DATA_W-1:0] BS_CH     = DATA_W'(8);

    localparam logic [1:0] OP_PUTC  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_SETC  = 2'b11;

    typedef enum logic [1:0] {IDLE, CLEAR, COPY, FILL} state_t;

    logic [2*DATA_W-1:0] mem [CELLS];

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic                vld_p1;
    logic [ADDR_W-1:0]   dst_p1;
    logic [2*DATA_W-1:0] rd_p1;

    logic                accept;
    logic                issue;
    logic                is_nl;
    logic                is_bs;
    logic [ADDR_W-1:0]   cur_col;
    logic                we_b;
    logic [ADDR_W-1:0]   waddr_b;
    logic [2*DATA_W-1:0] wdata_b;

    assign cmd.cmd_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign accept        = cmd.cmd_valid && (state == IDLE);
    assign issue         = (state == COPY) && (ptr < LAST_ROW);
    assign is_nl         = (cmd.cmd_ch == NL_CH);
    assign is_bs         = (cmd.cmd_ch == BS_CH);
    assign cur_col       = cursor_addr % COLS_A;

    // ---- port A: VGA read, registered, read-first against port B ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch    <= '0;
            color <= '0;
        end else if (vga_addr < CELLS_A) begin
            {ch, color} <= mem[vga_addr];
        end else begin
            ch    <= '0;
            color <= '0;
        end
    end

    // ---- port B: engine write select ----
    always_comb begin
        we_b    = 1'b0;
        waddr_b = ptr;
        wdata_b = {BLANK_D, DATA_W'(0)};
        case (state)
            CLEAR, FILL: we_b = 1'b1;
            COPY: begin
                we_b    = vld_p1;
                waddr_b = dst_p1;
                wdata_b = rd_p1;
            end
            IDLE: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        OP_PUTC: begin
                            if (is_bs) begin
                                we_b    = (cur_col != '0);
                                waddr_b = cursor_addr - ONE_A;
                            end else if (!is_nl) begin
                                we_b    = 1'b1;
                                waddr_b = cursor_addr;
                                wdata_b = {cmd.cmd_ch, cmd.cmd_color};
                            end
                        end
                        OP_WRITE: begin
                            we_b    = (cmd.cmd_addr < CELLS_A);
                            waddr_b = cmd.cmd_addr;
                            wdata_b = {cmd.cmd_ch, cmd.cmd_color};
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    // ---- port B: memory write, scroll-source read (p0 -> p1) ----
    always_ff @(posedge clk) begin
        if (we_b) begin
            mem[waddr_b] <= wdata_b;
        end
        if (issue) begin
            rd_p1  <= mem[ptr + COLS_A];
            dst_p1 <= ptr;
        end
    end

    // ---- engine FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CLEAR;
            ptr         <= '0;
            cursor_addr <= '0;
            vld_p1      <= 1'b0;
        end else begin
            vld_p1 <= issue;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (cmd.cmd_op)
                            OP_PUTC: begin
                                if (is_nl) begin
                                    if (cursor_addr < LAST_ROW) begin
                                        cursor_addr <= cursor_addr - cur_col + COLS_A;
                                    end else begin
                                        state <= COPY;
                                        ptr   <= '0;
                                    end
                                end else if (is_bs) begin
                                    if (cur_col != '0) begin
                                        cursor_addr <= cursor_addr - ONE_A;
                                    end
                                end else if (cursor_addr < LAST_CELL) begin
                                    cursor_addr <= cursor_addr + ONE_A;
                                end else begin
                                    state <= COPY;
                                    ptr   <= '0;
                                end
                            end
                            OP_CLEAR: begin
                                state <= CLEAR;
                                ptr   <= '0;
                            end
                            OP_SETC: begin
                                if (cmd.cmd_addr < CELLS_A) begin
                                    cursor_addr <= cmd.cmd_addr;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                CLEAR: begin
                    if (ptr == LAST_CELL) begin
                        state       <= IDLE;
                        ptr         <= '0;
                        cursor_addr <= '0;
                    end else begin
                        ptr <= ptr + ONE_A;
                    end
                end
                COPY: begin
                    // The cycle after the last issue only drains the pending write.
                    if (issue) begin
                        ptr <= ptr + ONE_A;
                    end else begin
                        state <= FILL;
                        ptr   <= LAST_ROW;
                    end
                end
                FILL: begin
                    if (ptr == LAST_CELL) begin
                        state       <= IDLE;
                        ptr         <= '0;
                        cursor_addr <= LAST_ROW;
                    end else begin
                        ptr <= ptr + ONE_A;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule

// File: doc/vga_text_buffer.md
Name: vga_text_buffer

Overview:
- Character/colour frame store and terminal engine sitting directly upstream of the VGA scan-out block.
- Holds a COLS x ROWS grid (96 x 32 = 3072 cells) of 8-bit character codes and 8-bit colour codes.
- The VGA block reads cells through vga_addr and receives ch and color.
- A single command port lets the CPU/MMIO side put characters at a cursor, write arbitrary cells, clear the screen and move the cursor; the engine scrolls automatically.

Parameters:
- COLS, 96, characters per row.
- ROWS, 32, rows per screen.
- ADDR_W, 12, cell address width; CELLS = COLS*ROWS = 3072.
- DATA_W, 8, width of ch and color.
- BLANK_CH, 32, character code written by clear, scroll fill and backspace.

Ports:
- clk  in  1  system clock (40 MHz pixel clock domain).
- rst_n  in  1  asynchronous active-low reset.
- vga_addr  in  ADDR_W  cell address from VGA, row-major = COLS*y + x.
- ch  out  DATA_W  character code of the cell at vga_addr.
- color  out  DATA_W  colour code of the cell at vga_addr.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_op  in  2  00 PUTC, 01 WRITE, 10 CLEAR, 11 SET_CURSOR.
- cmd_addr  in  ADDR_W  target cell for WRITE and SET_CURSOR.
- cmd_ch  in  DATA_W  character for PUTC and WRITE.
- cmd_color  in  DATA_W  colour for PUTC and WRITE.
- cursor_addr  out  ADDR_W  current cursor cell.
- busy  out  1  multi-cycle operation (CLEAR or SCROLL) in progress.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Storage: dual-port memory (BRAM inference). Port A is VGA read-only. Port B is engine read/write. Memory contents are not reset.
- VGA read: ch/color are registered, with 1-cycle latency from vga_addr. vga_addr >= CELLS returns 0/0.
- Same-address collision: if port B writes the cell port A reads in the same cycle, port A returns the old data (read-first).
- Reset values: ch=0, color=0, cmd_ready=0, busy=1, cursor_addr=0.
- Reset entry and abort: reset forces state CLEAR with fill pointer 0. Reset mid-operation aborts that operation and restarts the clear on release.
- Handshake: a command is accepted when cmd_valid && cmd_ready. cmd_ready = (state==IDLE).
- Single-cycle commands complete in the acceptance cycle, so cmd_ready stays high in IDLE for back-to-back commands.
- States: IDLE, CLEAR, COPY, FILL.
- CLEAR: writes {BLANK_CH, 0} to cells 0..CELLS-1, one per cycle (3072 cycles). Then cursor_addr=0 and state goes to IDLE.
- COPY: for dst = 0..COLS*(ROWS-1)-1, reads cell dst+COLS and writes it to dst one cycle later (pipelined). Lasts 2976 issue cycles plus 1 drain cycle, then goes to FILL.
- FILL: writes {BLANK_CH, 0} to the last row, cells 2976..3071 (96 cycles). Then cursor_addr = 2976 and state goes to IDLE.
- busy = (state != IDLE).
- PUTC, cursor col = cursor_addr mod COLS, row = cursor_addr / COLS:
  - cmd_ch == 10 (newline): if row < ROWS-1, cursor = (row+1)*COLS; else enter COPY.
  - cmd_ch == 8 (backspace): if col > 0, cursor -= 1 and {BLANK_CH, 0} is written at the new cursor; at col 0, no-op.
  - Otherwise: write {cmd_ch, cmd_color} at cursor. If cursor < CELLS-1, cursor += 1 (wraps naturally to the next row start). If cursor == CELLS-1, write the cell, then enter COPY (scroll). After the scroll the cursor is 2976.
- WRITE: writes {cmd_ch, cmd_color} at cmd_addr. Cursor unchanged. cmd_addr >= CELLS: command accepted and ignored.
- CLEAR op: enters CLEAR (same as the reset sequence).
- SET_CURSOR: cursor_addr = cmd_addr. cmd_addr >= CELLS: accepted and ignored.
- Port A is never stalled by engine activity. The VGA may show partially scrolled frames (no tearing protection).

Test Plan:
- Reset release: busy=1 and cmd_ready=0 for exactly 3072 cycles, then ready=1, cursor=0. Every vga_addr in 0..3071 reads ch=32, color=0 one cycle later.
- PUTC 'A' (65, color 2) x3 from cursor 0: cells 0..2 = {65,2}, cursor=3. PUTC 10: cursor=96. PUTC 8 at col 0: no change.
- SET_CURSOR 100, then PUTC 8: cursor=99 and cell 99={32,0}. WRITE addr 3072: nothing changes, ready remains 1.
- Scroll: preload row r with ch=r (r = 0..31). SET_CURSOR 3071, PUTC 'Z': busy for 2977+96 cycles. Afterwards row r holds ch=r+1 for r < 30, row 30 holds 31 except col 95 = 'Z', row 31 is blank, and cursor=2976.
- Collision: write {7,7} to cell 5 while vga_addr=5. The read in that cycle returns the old value; the next read returns {7,7}.
- Reset asserted mid-COPY: outputs immediately go to reset values, and the CLEAR sequence restarts on release (3072 cycles).
